// File: rtl/stream_bus_master.sv
// Byte-stream to bus bridge: parses OP/ADDR/LEN frames from an RX stream into single-byte
// bus write or read cycles, and returns read bytes on a TX stream.
module stream_bus_master #(
    parameter int ABUSWIDTH = 16,
    parameter int DBUSWIDTH = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [7:0]           RX_DATA,
    input  logic                 RX_VALID,
    output logic                 RX_READY,
    output logic [7:0]           TX_DATA,
    output logic                 TX_VALID,
    input  logic                 TX_READY,
    output logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [DBUSWIDTH-1:0] BUS_DATA,
    output logic                 BUS_RD,
    output logic                 BUS_WR,
    output logic                 BUSY,
    output logic                 CMD_ERR
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_WR_DATA,
        S_WR_STROBE,
        S_RD_STROBE,
        S_RD_CAPTURE,
        S_RD_TX
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            addr_h_q, addr_h_d;
    logic [ABUSWIDTH-1:0]  addr_q, addr_d;
    logic [ABUSWIDTH-1:0]  bus_add_q, bus_add_d;
    logic [15:0]           len_q, len_d;
    logic [DBUSWIDTH-1:0]  wdata_q, wdata_d;
    logic [DBUSWIDTH-1:0]  tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  rd_op_q, rd_op_d;
    logic                  inc_q, inc_d;
    logic                  cmd_err_q, cmd_err_d;

    logic                  rx_ready_st;
    logic                  rx_hs;
    logic [15:0]           full_addr;
    logic [ABUSWIDTH-1:0]  addr_step;

    always_comb begin
        rx_ready_st = (state_q == S_IDLE)  || (state_q == S_ADDR_H) ||
                      (state_q == S_ADDR_L) || (state_q == S_LEN_H)  ||
                      (state_q == S_LEN_L)  || (state_q == S_WR_DATA);
    end

    // Ready is masked while reset is held so nothing is accepted during reset.
    assign RX_READY  = rx_ready_st & ~BUS_RST;
    assign rx_hs     = RX_VALID & RX_READY;
    assign full_addr = {addr_h_q, RX_DATA};
    assign addr_step = inc_q ? (addr_q + ABUSWIDTH'(1)) : addr_q;

    always_comb begin
        state_d    = state_q;
        addr_h_d   = addr_h_q;
        addr_d     = addr_q;
        bus_add_d  = bus_add_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rd_op_d    = rd_op_q;
        inc_d      = inc_q;
        cmd_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    case (RX_DATA)
                        8'h01: begin rd_op_d = 1'b0; inc_d = 1'b1; state_d = S_ADDR_H; end
                        8'h02: begin rd_op_d = 1'b1; inc_d = 1'b1; state_d = S_ADDR_H; end
                        8'h05: begin rd_op_d = 1'b0; inc_d = 1'b0; state_d = S_ADDR_H; end
                        8'h06: begin rd_op_d = 1'b1; inc_d = 1'b0; state_d = S_ADDR_H; end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            S_ADDR_H: begin
                if (rx_hs) begin
                    addr_h_d = RX_DATA;
                    state_d  = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (rx_hs) begin
                    addr_d  = full_addr[ABUSWIDTH-1:0];
                    state_d = S_LEN_H;
                end
            end
            S_LEN_H: begin
                if (rx_hs) begin
                    len_d   = {RX_DATA, 8'h00};
                    state_d = S_LEN_L;
                end
            end
            S_LEN_L: begin
                if (rx_hs) begin
                    len_d = {len_q[15:8], RX_DATA};
                    if (len_d == 16'd0) begin
                        state_d = S_IDLE;
                    end else if (rd_op_q) begin
                        state_d = S_RD_STROBE;
                    end else begin
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: begin
                if (rx_hs) begin
                    wdata_d = RX_DATA;
                    state_d = S_WR_STROBE;
                end
            end
            S_WR_STROBE: begin
                len_d   = len_q - 16'd1;
                addr_d  = addr_step;
                state_d = (len_q == 16'd1) ? S_IDLE : S_WR_DATA;
            end
            S_RD_STROBE: begin
                state_d = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                // Slaves present read data the cycle after the strobe.
                tx_data_d  = BUS_DATA;
                tx_valid_d = 1'b1;
                state_d    = S_RD_TX;
            end
            S_RD_TX: begin
                if (TX_READY) begin
                    tx_valid_d = 1'b0;
                    len_d      = len_q - 16'd1;
                    addr_d     = addr_step;
                    state_d    = (len_q == 16'd1) ? S_IDLE : S_RD_STROBE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // BUS_ADD only moves when a strobe cycle is about to start.
        if ((state_d == S_WR_STROBE) || (state_d == S_RD_STROBE)) begin
            bus_add_d = addr_d;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q    <= S_IDLE;
            addr_h_q   <= '0;
            addr_q     <= '0;
            bus_add_q  <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rd_op_q    <= 1'b0;
            inc_q      <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_h_q   <= addr_h_d;
            addr_q     <= addr_d;
            bus_add_q  <= bus_add_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rd_op_q    <= rd_op_d;
            inc_q      <= inc_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign BUS_WR   = (state_q == S_WR_STROBE);
    assign BUS_RD   = (state_q == S_RD_STROBE);
    assign BUS_DATA = (state_q == S_WR_STROBE) ? wdata_q : {DBUSWIDTH{1'bz}};
    assign BUS_ADD  = bus_add_q;
    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign BUSY     = (state_q != S_IDLE);
    assign CMD_ERR  = cmd_err_q;

endmodule

// File: tb/tb_stream_bus_master.sv
// Directed bench for stream_bus_master: frames in on RX, bus cycles and TX bytes observed
// by monitors, with a slave model that returns (address low byte + 1) after each read strobe.
module tb_stream_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] bus_add;
    wire  [7:0]  bus_data;
    logic        bus_rd;
    logic        bus_wr;
    logic        busy;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [23:0] wr_q[$];
    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [7:0]  tx_q[$];
    logic        overlap_seen = 1'b0;

    logic        slv_drv = 1'b0;
    logic [7:0]  slv_q   = 8'h00;

    always #5 clk = ~clk;

    stream_bus_master #(.ABUSWIDTH(16), .DBUSWIDTH(8)) dut (
        .BUS_CLK (clk),
        .BUS_RST (rst),
        .RX_DATA (rx_data),
        .RX_VALID(rx_valid),
        .RX_READY(rx_ready),
        .TX_DATA (tx_data),
        .TX_VALID(tx_valid),
        .TX_READY(tx_ready),
        .BUS_ADD (bus_add),
        .BUS_DATA(bus_data),
        .BUS_RD  (bus_rd),
        .BUS_WR  (bus_wr),
        .BUSY    (busy),
        .CMD_ERR (cmd_err)
    );

    assign bus_data = slv_drv ? slv_q : 8'hzz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_rd) begin
            slv_q   <= bus_add[7:0] + 8'd1;
            slv_drv <= 1'b1;
            rd_addr_q.push_back(bus_add);
            rd_cyc_q.push_back(cyc);
        end else begin
            slv_drv <= 1'b0;
        end
        if (bus_wr) wr_q.push_back({bus_add, bus_data});
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (bus_rd && bus_wr) overlap_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("rx_accept", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        tx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        int   n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        tick();
        tick();

        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_bus_rd",   {31'd0, bus_rd},   32'd0);
        chk("rst_bus_wr",   {31'd0, bus_wr},   32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_cmd_err",  {31'd0, cmd_err},  32'd0);
        chk("rst_bus_add",  {16'd0, bus_add},  32'd0);
        rst = 1'b0;
        tick();
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Incrementing write of two bytes
        clear_mon();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'hAA);
        send_byte(8'h55);
        chk("w1_strobe",   {31'd0, bus_wr},   32'd1);
        chk("w1_addr",     {16'd0, bus_add},  32'h0011);
        chk("w1_data",     {24'd0, bus_data}, 32'h55);
        chk("w1_busy_hi",  {31'd0, busy},     32'd1);
        tick();
        chk("w1_busy_lo",  {31'd0, busy},     32'd0);
        chk("w1_wr_lo",    {31'd0, bus_wr},   32'd0);
        chk("w1_add_hold", {16'd0, bus_add},  32'h0011);
        chk("w1_count",    wr_q.size(),       32'd2);
        if (wr_q.size() == 2) begin
            chk("w1_first",  {8'd0, wr_q[0]}, 32'h0010AA);
            chk("w1_second", {8'd0, wr_q[1]}, 32'h001155);
        end

        // Incrementing read of three bytes, consumer always ready
        clear_mon();
        tx_ready = 1'b1;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h00); send_byte(8'h03);
        wait_idle();
        chk("r1_rd_count", rd_addr_q.size(), 32'd3);
        chk("r1_tx_count", tx_q.size(),      32'd3);
        if (tx_q.size() == 3 && rd_addr_q.size() == 3) begin
            chk("r1_tx0",   {24'd0, tx_q[0]},      32'h21);
            chk("r1_tx1",   {24'd0, tx_q[1]},      32'h22);
            chk("r1_tx2",   {24'd0, tx_q[2]},      32'h23);
            chk("r1_addr2", {16'd0, rd_addr_q[2]}, 32'h0022);
            chk("r1_gap01", rd_cyc_q[1] - rd_cyc_q[0], 32'd3);
            chk("r1_gap12", rd_cyc_q[2] - rd_cyc_q[1], 32'd3);
        end
        chk("r1_tx_valid_lo", {31'd0, tx_valid}, 32'd0);

        // Fixed-address read with a stalled consumer
        clear_mon();
        tx_ready = 1'b0;
        send_byte(8'h06); send_byte(8'h00); send_byte(8'h30);
        send_byte(8'h00); send_byte(8'h02);
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("r2_tx_valid", {31'd0, tx_valid}, 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_valid !== 1'b1 || tx_data !== 8'h31 || bus_rd !== 1'b0) stable = 1'b0;
        end
        chk("r2_stable",   {31'd0, stable},  32'd1);
        chk("r2_one_read", rd_addr_q.size(), 32'd1);
        tx_ready = 1'b1;
        wait_idle();
        chk("r2_tx_count", tx_q.size(), 32'd2);
        if (tx_q.size() == 2 && rd_addr_q.size() == 2) begin
            chk("r2_tx0",   {24'd0, tx_q[0]},      32'h31);
            chk("r2_tx1",   {24'd0, tx_q[1]},      32'h31);
            chk("r2_addr0", {16'd0, rd_addr_q[0]}, 32'h0030);
            chk("r2_addr1", {16'd0, rd_addr_q[1]}, 32'h0030);
        end

        // Address wrap at the top of the space
        clear_mon();
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h11);
        send_byte(8'h22);
        wait_idle();
        chk("wrap_count", wr_q.size(), 32'd2);
        if (wr_q.size() == 2) begin
            chk("wrap_first",  {8'd0, wr_q[0]}, 32'hFFFF11);
            chk("wrap_second", {8'd0, wr_q[1]}, 32'h000022);
        end

        // Unknown opcode followed by a zero-length read
        clear_mon();
        send_byte(8'h7F);
        chk("err_pulse",    {31'd0, cmd_err}, 32'd1);
        chk("err_idle",     {31'd0, busy},    32'd0);
        tick();
        chk("err_pulse_end", {31'd0, cmd_err}, 32'd0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        chk("len0_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("len0_no_rd",    rd_addr_q.size(),  32'd0);
        chk("len0_tx_valid", {31'd0, tx_valid}, 32'd0);

        // Reset in the middle of a write payload
        clear_mon();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h00); send_byte(8'h03); send_byte(8'hAA);
        tick();
        chk("mid_busy",     {31'd0, busy},     32'd1);
        chk("mid_rx_ready", {31'd0, rx_ready}, 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("abort_busy",     {31'd0, busy},     32'd0);
        chk("abort_bus_add",  {16'd0, bus_add},  32'd0);
        chk("abort_tx_data",  {24'd0, tx_data},  32'd0);
        chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_bus_wr",   {31'd0, bus_wr},   32'd0);
        chk("abort_bus_rd",   {31'd0, bus_rd},   32'd0);
        chk("abort_cmd_err",  {31'd0, cmd_err},  32'd0);
        rst = 1'b0;
        tick();
        chk("abort_wr_count", wr_q.size(), 32'd1);
        clear_mon();
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h50);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h77);
        send_byte(8'h88);
        wait_idle();
        chk("fresh_count", wr_q.size(), 32'd2);
        if (wr_q.size() == 2) begin
            chk("fresh_first",  {8'd0, wr_q[0]}, 32'h005077);
            chk("fresh_second", {8'd0, wr_q[1]}, 32'h005088);
        end

        chk("no_rd_wr_overlap", {31'd0, overlap_seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_bus_master.md
Name: stream_bus_master

Overview:
- Byte-stream-to-bus bridge acting as master of the shared BUS_RD/BUS_WR/BUS_ADD/BUS_DATA bus; sits directly upstream of every per-core bus slave decoder.
- Parses command frames arriving on an 8-bit valid/ready RX stream (from UART/USB/SiTCP receive FIFO) and issues single-byte bus write or read cycles.
- Returns read bytes on an 8-bit valid/ready TX stream.

Parameters:
- ABUSWIDTH, 16, bus address width; legal range 9..16. Frame address is always 16 bits, and the low ABUSWIDTH bits are used.
- DBUSWIDTH, 8, bus data width; fixed at 8, other values are illegal.

Ports:
- BUS_CLK  in  1  single clock for all logic.
- BUS_RST  in  1  synchronous, active-high reset.
- RX_DATA  in  8  command/payload byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  byte accepted when RX_VALID&RX_READY at the rising edge.
- TX_DATA  out  8  read-back byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  consumer accepts when TX_VALID&TX_READY.
- BUS_ADD  out  ABUSWIDTH  bus address.
- BUS_DATA  inout  8  driven only in the BUS_WR cycle, else high-Z.
- BUS_RD  out  1  read strobe.
- BUS_WR  out  1  write strobe.
- BUSY  out  1  high in any state other than IDLE.
- CMD_ERR  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Frame format: OP, ADDR[15:8], ADDR[7:0], LEN[15:8], LEN[7:0], then LEN payload bytes for writes only. LEN counts data bytes.
- Opcodes:
  - 0x01 write, incrementing address.
  - 0x02 read, incrementing address.
  - 0x05 write, fixed address (FIFO port).
  - 0x06 read, fixed address.
  - Any other opcode is consumed, CMD_ERR pulses 1 cycle, and the FSM stays in IDLE.
- Reset values: RX_READY=0, TX_VALID=0, TX_DATA=0, BUS_ADD=0, BUS_RD=0, BUS_WR=0, BUS_DATA=Z, BUSY=0, CMD_ERR=0. State goes to IDLE and the length counter clears.
- BUS_RST mid-frame aborts immediately; partially received frame bytes are discarded, and any pending TX byte is dropped.
- FSM states: IDLE -> ADDR_H -> ADDR_L -> LEN_H -> LEN_L -> (WR_DATA | RD_STROBE | IDLE).
  - RX_READY=1 in IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L and WR_DATA; 0 elsewhere.
  - Each header state advances only on an RX handshake.
- LEN=0: after LEN_L, return to IDLE with no bus cycles.
- Write path:
  - WR_DATA: on RX handshake, latch the byte and go to WR_STROBE.
  - WR_STROBE: exactly one cycle with BUS_WR=1, BUS_ADD=current address, BUS_DATA=latched byte.
  - Next cycle: decrement the counter and increment the address (if incrementing). Return to WR_DATA, or to IDLE if the counter reaches 0.
  - Minimum 2 cycles per written byte.
- Read path:
  - RD_STROBE: one cycle with BUS_RD=1 and BUS_ADD valid.
  - RD_CAPTURE (next cycle): BUS_ADD is held, BUS_DATA is sampled into TX_DATA (slaves return data one clock after BUS_RD), TX_VALID is set.
  - RD_TX: hold TX_VALID/TX_DATA stable until TX_READY. On handshake, clear TX_VALID, decrement the counter and step the address, then go to RD_STROBE or IDLE.
  - TX_READY already high in RD_TX completes in 1 cycle, so minimum 3 cycles per read byte.
  - TX_VALID never deasserts without a handshake except on reset.
- Address wraps from 2^ABUSWIDTH-1 to 0 when incrementing; the fixed-address variants never change BUS_ADD within a frame.
- BUS_RD and BUS_WR are never high in the same cycle. Outside strobe/capture cycles both are 0, and BUS_ADD holds its last value.
- RX_VALID during RD_* states is ignored (RX_READY=0) and the byte stays pending at the source.
- Counter is 16-bit, so LEN=0xFFFF is fully supported.

Test Plan:
- Frame 01 00 10 00 02 AA 55 -> BUS_WR pulses: addr 0x0010 data 0xAA, then addr 0x0011 data 0x55. BUS_DATA is Z outside those cycles; BUSY falls after the second write.
- Frame 02 00 20 00 03, slave model returns addr low byte +1 one cycle after BUS_RD, TX_READY=1 -> TX bytes 0x21, 0x22, 0x23. BUS_RD asserts 3 times with 3-cycle spacing.
- Frame 06 00 30 00 02, TX_READY held low 10 cycles after the first TX_VALID -> TX_DATA stable throughout, no second BUS_RD until the handshake, both reads at 0x0030.
- Frame 01 FF FF 00 02 11 22 with ABUSWIDTH=16 -> writes to 0xFFFF, then 0x0000.
- Opcode 0x7F followed by a valid 02 00 00 00 00 frame -> CMD_ERR single-cycle pulse. The LEN=0 frame completes with no BUS_RD and TX_VALID stays 0.
- Assert BUS_RST in the WR_DATA state after 1 of 3 payload bytes -> all outputs at reset values the next cycle. A following fresh frame executes correctly.
